board_scan_reader: RTL
======================

// Module: board_scan_reader
// PURPOSE
//  Read side of the 32-square board store written by the game logic (addr/piece/en writer port).
//  Once per frame, walks squares 0..NUM_SQUARES-1, reads each 5-bit {color,piece,state} entry,
//  tags it with cursor/selection flags, and streams (addr,piece,flags) to the draw engine over
//  a valid/ready handshake. Sits between board storage and the VGA draw path.
// PARAMETERS
//  NUM_SQUARES  32  squares scanned per pass (addresses 0..NUM_SQUARES-1)
//  ADDR_W       5   square address width; NUM_SQUARES <= 2**ADDR_W
//  PIECE_W      5   board entry width {COLOR,PIECE[2:0],STATE}
// PORTS
//  CLK            in   1        system clock (50 MHz)
//  RESET_N        in   1        asynchronous, active-low reset
//  frame_start    in   1        1-cycle pulse requesting a scan pass (from vsync)
//  rd_addr        out  ADDR_W   board store read address
//  rd_data        in   PIECE_W  board entry for rd_addr, valid exactly 1 cycle after rd_addr
//  cursor_addr    in   ADDR_W   current cursor square
//  selected_addr  in   ADDR_W   currently selected square
//  select_en      in   1        selected_addr meaningful
//  sq_valid       out  1        output square record valid
//  sq_ready       in   1        draw engine accepts record
//  sq_addr        out  ADDR_W   square address of record
//  sq_piece       out  PIECE_W  board entry of record
//  sq_flags       out  2        {is_selected, is_cursor}
//  scan_busy      out  1        pass in progress
//  scan_done      out  1        1-cycle pulse after last record of a pass is accepted
// BEHAVIOUR
//  - Reset (async, any state): FSM->IDLE; rd_addr=0, sq_valid=0, sq_addr=0, sq_piece=0,
//    sq_flags=0, scan_busy=0, scan_done=0, pending=0, all shadow-valid bits cleared.
//  - FSM: IDLE -frame_start|pending-> ISSUE (drive rd_addr=idx) -> WAIT (1 cycle) -> CAPTURE
//    (latch rd_data, compute flags) -> EMIT (sq_valid=1 held, record stable) -> on sq_valid&sq_ready:
//    idx==NUM_SQUARES-1 ? DONE : idx+1, ISSUE. DONE pulses scan_done 1 cycle, -> IDLE.
//  - Latency per square without backpressure: 4 cycles frame_start..first sq_valid, 4/square.
//  - Handshake: once sq_valid rises, sq_addr/sq_piece/sq_flags and sq_valid hold until accepted;
//    transfer occurs on the cycle sq_valid&sq_ready; sq_ready while sq_valid=0 ignored.
//  - Flags sampled in CAPTURE: is_cursor=(idx==cursor_addr); is_selected=select_en&(idx==selected_addr).
//  - frame_start while scan_busy: sets pending (single bit, extra pulses merge); new pass starts
//    from IDLE the cycle after DONE. frame_start in the DONE cycle also sets pending.
//  - idx counter ADDR_W wide, never exceeds NUM_SQUARES-1; no wrap past the last square.
//  - scan_busy=1 in every state except IDLE.
//  - Board writes during a pass are not blocked; each square reflects the store at its ISSUE cycle.
// CONFIGURATION
//  BANQI_DIRTY_SCAN_EN defined: per-square shadow {valid,piece,flags}; in CAPTURE, if shadow valid
//   and equal to {rd_data,flags}, skip EMIT (go to next/ DONE directly); on accept, shadow updated.
//   After reset every square emits once (shadow invalid). scan_done still pulses each pass,
//   including passes that emit zero records.
//  Undefined: no shadow storage; every pass emits all NUM_SQUARES records.
// STRUCTURE
//  Shared package banqi_pkg: PIECE_* (3-bit), COLOR_RED/BLACK, STATE_COVERED/UNCOVERED,
//   NUM_SQUARES, ADDR_W, PIECE_W, square-record flag bit positions.
//  Sub-module: board_shadow_ram (NUM_SQUARES x (1+PIECE_W+2), async clear of valid bits,
//   compare output), instantiated only under BANQI_DIRTY_SCAN_EN. FSM+counter stay in top.
// TESTING
//  1 Store = initial layout, sq_ready=1, one frame_start -> 32 records addr 0..31 in order,
//    addr 0 piece 5'b1_100_0, addr 28 piece 5'b0_111_0, scan_done once after addr 31.
//  2 sq_ready low 10 cycles on addr 5 -> sq_valid/sq_addr=5/sq_piece held stable, no addr 6 issued.
//  3 cursor_addr=9, selected_addr=12, select_en=1 -> flags 2'b01 on 9, 2'b10 on 12, 00 elsewhere;
//    select_en=0 -> addr 12 flags 2'b00.
//  4 Three frame_start pulses mid-pass -> exactly one further pass starting after scan_done.
//  5 RESET_N low at addr 17 EMIT -> all outputs zero immediately, IDLE; next frame_start restarts at 0.
//  6 DIRTY_SCAN_EN: pass 1 emits 32; change square 20 to 5'b0_001_1 -> pass 2 emits only addr 20;
//    move cursor 9->10 -> pass 3 emits 9 and 10; no change -> pass 4 zero records, scan_done pulses.

Source files
------------

// File: rtl/banqi_pkg.sv
// Shared Banqi definitions: board geometry, square-entry field encodings,
// square-record flag bit positions and the scan FSM state type.
// Board entry layout (PIECE_W bits): {color, piece[2:0], state}.
package banqi_pkg;

  localparam int unsigned NUM_SQUARES = 32;
  localparam int unsigned ADDR_W      = 5;
  localparam int unsigned PIECE_W     = 5;
  localparam int unsigned FLAGS_W     = 2;

  localparam logic [2:0] PIECE_EMPTY    = 3'd0;
  localparam logic [2:0] PIECE_SOLDIER  = 3'd1;
  localparam logic [2:0] PIECE_CANNON   = 3'd2;
  localparam logic [2:0] PIECE_HORSE    = 3'd3;
  localparam logic [2:0] PIECE_CHARIOT  = 3'd4;
  localparam logic [2:0] PIECE_ELEPHANT = 3'd5;
  localparam logic [2:0] PIECE_ADVISOR  = 3'd6;
  localparam logic [2:0] PIECE_GENERAL  = 3'd7;

  localparam logic COLOR_BLACK = 1'b0;
  localparam logic COLOR_RED   = 1'b1;

  localparam logic STATE_COVERED   = 1'b0;
  localparam logic STATE_UNCOVERED = 1'b1;

  // sq_flags = {is_selected, is_cursor}
  localparam int unsigned FLAG_CURSOR_BIT   = 0;
  localparam int unsigned FLAG_SELECTED_BIT = 1;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCapture,
    StEmit,
    StDone
  } scan_state_e;

endpackage

// File: rtl/board_scan_reader_if.sv
// Square-record stream from the board scan reader to the draw engine.
//   sq_valid : record valid (held until accepted)
//   sq_ready : draw engine accepts record
//   sq_addr  : square address
//   sq_piece : board entry {color, piece, state}
//   sq_flags : {is_selected, is_cursor}
// master = record source (scan reader), slave = draw engine.
interface board_scan_reader_if
  import banqi_pkg::*;
#(
  parameter int unsigned AddrW  = ADDR_W,
  parameter int unsigned PieceW = PIECE_W
);
  logic               sq_valid;
  logic               sq_ready;
  logic [AddrW-1:0]   sq_addr;
  logic [PieceW-1:0]  sq_piece;
  logic [FLAGS_W-1:0] sq_flags;

  modport master (
    output sq_valid,
    output sq_addr,
    output sq_piece,
    output sq_flags,
    input  sq_ready
  );

  modport slave (
    input  sq_valid,
    input  sq_addr,
    input  sq_piece,
    input  sq_flags,
    output sq_ready
  );
endinterface

// File: rtl/board_shadow_ram.sv
// Per-square shadow of the last record accepted by the draw engine.
// Only built when BANQI_DIRTY_SCAN_EN is defined.
//   CLK, RESET_N : clock, async active-low reset (clears valid bits only)
//   rd_idx       : square being compared
//   cmp_data     : candidate {piece, flags}
//   hit          : shadow valid for rd_idx and equal to cmp_data
//   wr_en/wr_idx/wr_data : store an accepted record
`ifdef BANQI_DIRTY_SCAN_EN
module board_shadow_ram
  import banqi_pkg::*;
#(
  parameter int unsigned NumSquares = NUM_SQUARES,
  parameter int unsigned AddrW      = ADDR_W,
  parameter int unsigned DataW      = PIECE_W + FLAGS_W
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [AddrW-1:0] rd_idx,
  input  logic [DataW-1:0] cmp_data,
  output logic             hit,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_idx,
  input  logic [DataW-1:0] wr_data
);
  logic [NumSquares-1:0] valid_q;
  logic [DataW-1:0]      data_q [NumSquares];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only trusted behind its valid bit.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      data_q[wr_idx] <= wr_data;
    end
  end

  assign hit = valid_q[rd_idx] && (data_q[rd_idx] == cmp_data);
endmodule
`endif

// File: rtl/board_scan_reader.sv
// Board scan reader: once per frame walks squares 0..NumSquares-1 of the board store,
// tags each entry with cursor/selection flags and streams records to the draw engine.
//   CLK, RESET_N   : clock, async active-low reset
//   frame_start    : pass request pulse; requests during a pass merge into one pending bit
//   rd_addr/rd_data: board store read port, data one cycle after address
//   cursor_addr, selected_addr, select_en : flag sources, sampled in CAPTURE
//   sq             : record stream (master modport)
//   scan_busy      : high in every state except IDLE
//   scan_done      : one-cycle pulse after the last record of a pass
// Optional feature macro BANQI_DIRTY_SCAN_EN: skip squares whose {piece, flags} match the
// last accepted record for that square.
module board_scan_reader
  import banqi_pkg::*;
#(
  parameter int unsigned NumSquares = NUM_SQUARES,
  parameter int unsigned AddrW      = ADDR_W,
  parameter int unsigned PieceW     = PIECE_W
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                frame_start,
  output logic [AddrW-1:0]    rd_addr,
  input  logic [PieceW-1:0]   rd_data,
  input  logic [AddrW-1:0]    cursor_addr,
  input  logic [AddrW-1:0]    selected_addr,
  input  logic                select_en,
  board_scan_reader_if.master sq,
  output logic                scan_busy,
  output logic                scan_done
);
  scan_state_e        state_q, state_d;
  logic [AddrW-1:0]   idx_q, idx_d;
  logic               pending_q, pending_d;
  logic [AddrW-1:0]   addr_q, addr_d;
  logic [PieceW-1:0]  piece_q, piece_d;
  logic [FLAGS_W-1:0] flags_q, flags_d;
  logic [FLAGS_W-1:0] cap_flags;
  logic               last_sq;
  logic               accept;

  assign last_sq = (idx_q == AddrW'(NumSquares - 1));
  assign accept  = (state_q == StEmit) && sq.sq_ready;

  always_comb begin
    cap_flags                    = '0;
    cap_flags[FLAG_CURSOR_BIT]   = (idx_q == cursor_addr);
    cap_flags[FLAG_SELECTED_BIT] = select_en && (idx_q == selected_addr);
  end

`ifdef BANQI_DIRTY_SCAN_EN
  logic shadow_hit;

  board_shadow_ram #(
    .NumSquares (NumSquares),
    .AddrW      (AddrW),
    .DataW      (PieceW + FLAGS_W)
  ) u_shadow (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .rd_idx   (idx_q),
    .cmp_data ({rd_data, cap_flags}),
    .hit      (shadow_hit),
    .wr_en    (accept),
    .wr_idx   (addr_q),
    .wr_data  ({piece_q, flags_q})
  );
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    piece_d   = piece_q;
    flags_d   = flags_q;
    // Any request outside IDLE (including the DONE cycle) is remembered.
    pending_d = pending_q | (frame_start & (state_q != StIdle));
    unique case (state_q)
      StIdle: begin
        if (frame_start || pending_q) begin
          state_d   = StIssue;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end
      StIssue: state_d = StWait;
      StWait:  state_d = StCapture;
      StCapture: begin
        addr_d  = idx_q;
        piece_d = rd_data;
        flags_d = cap_flags;
`ifdef BANQI_DIRTY_SCAN_EN
        if (shadow_hit) begin
          state_d = last_sq ? StDone : StIssue;
          idx_d   = last_sq ? idx_q : idx_q + AddrW'(1);
        end else begin
          state_d = StEmit;
        end
`else
        state_d = StEmit;
`endif
      end
      StEmit: begin
        if (sq.sq_ready) begin
          state_d = last_sq ? StDone : StIssue;
          idx_d   = last_sq ? idx_q : idx_q + AddrW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        idx_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      pending_q <= 1'b0;
      addr_q    <= '0;
      piece_q   <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      piece_q   <= piece_d;
      flags_q   <= flags_d;
    end
  end

  // idx is held from ISSUE through CAPTURE so the store's 1-cycle data lines up.
  assign rd_addr     = idx_q;
  assign sq.sq_valid = (state_q == StEmit);
  assign sq.sq_addr  = addr_q;
  assign sq.sq_piece = piece_q;
  assign sq.sq_flags = flags_q;
  assign scan_busy   = (state_q != StIdle);
  assign scan_done   = (state_q == StDone);
endmodule
